// File: rtl/cam_tr_monitor.sv
// cam_tr_monitor
// ---------------------------------------------------------------------------
// Purpose:
//   Passive transaction monitor for the lab CAM. Every CAM request is tagged
//   with a logical timestamp and then travels through a READ_LAT-deep capture
//   pipeline. Reads pick up their response (cam_val_o / cam_valid_o) in the
//   final stage. Completed transactions go into a show-ahead FIFO in request
//   order. A RESET token is emitted after every reset.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   cam_valid_i            CAM request strobe
//   cam_rw_n_i             1 = read, 0 = write
//   cam_key_i              request key
//   cam_val_i              write data
//   cam_val_o, cam_valid_o CAM read data / hit (inputs to this monitor)
//   tr_valid / tr_ready    FIFO head handshake (pop on tr_valid && tr_ready)
//   tr_type                0 = RESET, 1 = READ, 2 = WRITE
//   tr_key, tr_wdata,
//   tr_rdata, tr_valid_o,
//   tr_ltime               head transaction fields (all zero when FIFO empty)
//   drop_cnt               saturating count of transactions lost to a full FIFO
//   overflow               sticky flag: at least one drop since reset
//
// Optional feature (macro CAM_TRMON_COV_EN):
//   Adds sticky outputs cov_ww and cov_wr. They flag a WRITE that is followed,
//   at the next timestamp, by a WRITE of different data or by a READ to the
//   same key.
// ---------------------------------------------------------------------------
module cam_tr_monitor #(
  parameter int KEY_W    = 16,
  parameter int VAL_W    = 16,
  parameter int READ_LAT = 1,
  parameter int DEPTH    = 8,
  parameter int LTIME_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cam_valid_i,
  input  logic               cam_rw_n_i,
  input  logic [KEY_W-1:0]   cam_key_i,
  input  logic [VAL_W-1:0]   cam_val_i,
  input  logic [VAL_W-1:0]   cam_val_o,
  input  logic               cam_valid_o,
  output logic               tr_valid,
  input  logic               tr_ready,
  output logic [1:0]         tr_type,
  output logic [KEY_W-1:0]   tr_key,
  output logic [VAL_W-1:0]   tr_wdata,
  output logic [VAL_W-1:0]   tr_rdata,
  output logic               tr_valid_o,
  output logic [LTIME_W-1:0] tr_ltime,
  output logic [15:0]        drop_cnt,
`ifdef CAM_TRMON_COV_EN
  output logic               cov_ww,
  output logic               cov_wr,
`endif
  output logic               overflow
);

  localparam logic [1:0] TYPE_RESET = 2'd0;
  localparam logic [1:0] TYPE_READ  = 2'd1;
  localparam logic [1:0] TYPE_WRITE = 2'd2;

  localparam int          PTR_W   = $clog2(DEPTH);
  localparam int          LAST    = READ_LAT - 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------- ltime
  logic [LTIME_W-1:0] ltime_r;

  // Logical timestamp: 1 during reset, then free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      ltime_r <= LTIME_W'(1);
    end else begin
      ltime_r <= ltime_r + LTIME_W'(1);
    end
  end

  // ------------------------------------------------------ capture pipeline
  logic [READ_LAT-1:0] stg_vld_r;
  logic [1:0]          stg_type_r  [0:READ_LAT-1];
  logic [KEY_W-1:0]    stg_key_r   [0:READ_LAT-1];
  logic [VAL_W-1:0]    stg_wdata_r [0:READ_LAT-1];
  logic [LTIME_W-1:0]  stg_ltime_r [0:READ_LAT-1];

  // Non-stalling shift pipeline. Reset plants a single RESET token in stage 0
  // so it leaves the final stage READ_LAT cycles after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < READ_LAT; i++) begin
        stg_vld_r[i]   <= 1'b0;
        stg_type_r[i]  <= TYPE_RESET;
        stg_key_r[i]   <= {KEY_W{1'b0}};
        stg_wdata_r[i] <= {VAL_W{1'b0}};
        stg_ltime_r[i] <= {LTIME_W{1'b0}};
      end
      stg_vld_r[0]   <= 1'b1;
      stg_type_r[0]  <= TYPE_RESET;
      stg_key_r[0]   <= {KEY_W{1'b0}};
      stg_wdata_r[0] <= {VAL_W{1'b0}};
      stg_ltime_r[0] <= {LTIME_W{1'b0}};
    end else begin
      stg_vld_r[0]   <= cam_valid_i;
      stg_type_r[0]  <= cam_rw_n_i ? TYPE_READ : TYPE_WRITE;
      stg_key_r[0]   <= cam_key_i;
      stg_wdata_r[0] <= cam_rw_n_i ? {VAL_W{1'b0}} : cam_val_i;
      stg_ltime_r[0] <= ltime_r;
      for (int i = 1; i < READ_LAT; i++) begin
        stg_vld_r[i]   <= stg_vld_r[i-1];
        stg_type_r[i]  <= stg_type_r[i-1];
        stg_key_r[i]   <= stg_key_r[i-1];
        stg_wdata_r[i] <= stg_wdata_r[i-1];
        stg_ltime_r[i] <= stg_ltime_r[i-1];
      end
    end
  end

  // ------------------------------------------------- completed transaction
  logic               push_s;
  logic [VAL_W-1:0]   push_rdata_s;
  logic               push_hit_s;

  // Only reads carry the CAM response, sampled in the final-stage cycle.
  always_comb begin
    push_s       = stg_vld_r[LAST];
    push_rdata_s = {VAL_W{1'b0}};
    push_hit_s   = 1'b0;
    if (stg_type_r[LAST] == TYPE_READ) begin
      push_rdata_s = cam_val_o;
      push_hit_s   = cam_valid_o;
    end else begin
      push_rdata_s = {VAL_W{1'b0}};
      push_hit_s   = 1'b0;
    end
  end

  // ------------------------------------------------------------------ FIFO
  logic [1:0]         mem_type_r  [0:DEPTH-1];
  logic [KEY_W-1:0]   mem_key_r   [0:DEPTH-1];
  logic [VAL_W-1:0]   mem_wdata_r [0:DEPTH-1];
  logic [VAL_W-1:0]   mem_rdata_r [0:DEPTH-1];
  logic               mem_hit_r   [0:DEPTH-1];
  logic [LTIME_W-1:0] mem_ltime_r [0:DEPTH-1];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   cnt_r;
  logic [15:0]      drop_cnt_r;
  logic             overflow_r;

  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_ok_s;
  logic drop_s;

  // Handshake decode. A full FIFO still accepts a push when the head is
  // leaving in the same cycle.
  always_comb begin
    empty_s   = (cnt_r == {(PTR_W + 1){1'b0}});
    full_s    = (cnt_r == DEPTH_C);
    pop_s     = !empty_s && tr_ready;
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && full_s && !pop_s;
  end

  // Entry storage; data words need no reset because the head is gated by count.
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst) begin
      mem_type_r[wr_ptr_r]  <= stg_type_r[LAST];
      mem_key_r[wr_ptr_r]   <= stg_key_r[LAST];
      mem_wdata_r[wr_ptr_r] <= stg_wdata_r[LAST];
      mem_rdata_r[wr_ptr_r] <= push_rdata_s;
      mem_hit_r[wr_ptr_r]   <= push_hit_s;
      mem_ltime_r[wr_ptr_r] <= stg_ltime_r[LAST];
    end else begin
      mem_type_r[wr_ptr_r]  <= mem_type_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (PTR_W + 1)'(1);
        2'b01:   cnt_r <= cnt_r - (PTR_W + 1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Drop accounting: saturating counter plus sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 16'd0;
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != 16'hFFFF) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end else begin
      drop_cnt_r <= drop_cnt_r;
      overflow_r <= overflow_r;
    end
  end

  // Show-ahead head view; all fields forced to zero while the FIFO is empty.
  always_comb begin
    tr_valid   = 1'b0;
    tr_type    = TYPE_RESET;
    tr_key     = {KEY_W{1'b0}};
    tr_wdata   = {VAL_W{1'b0}};
    tr_rdata   = {VAL_W{1'b0}};
    tr_valid_o = 1'b0;
    tr_ltime   = {LTIME_W{1'b0}};
    if (!empty_s) begin
      tr_valid   = 1'b1;
      tr_type    = mem_type_r[rd_ptr_r];
      tr_key     = mem_key_r[rd_ptr_r];
      tr_wdata   = mem_wdata_r[rd_ptr_r];
      tr_rdata   = mem_rdata_r[rd_ptr_r];
      tr_valid_o = mem_hit_r[rd_ptr_r];
      tr_ltime   = mem_ltime_r[rd_ptr_r];
    end else begin
      tr_valid   = 1'b0;
    end
  end

  assign drop_cnt = drop_cnt_r;
  assign overflow = overflow_r;

`ifdef CAM_TRMON_COV_EN
  // ------------------------------------------------------------- coverage
  logic               prev_vld_r;
  logic [1:0]         prev_type_r;
  logic [KEY_W-1:0]   prev_key_r;
  logic [VAL_W-1:0]   prev_wdata_r;
  logic [LTIME_W-1:0] prev_ltime_r;
  logic               cov_ww_r;
  logic               cov_wr_r;
  logic               adj_s;

  // Previous accepted push was a WRITE one timestamp before the current push.
  always_comb begin
    adj_s = prev_vld_r && (prev_type_r == TYPE_WRITE) &&
            ((prev_ltime_r + LTIME_W'(1)) == stg_ltime_r[LAST]) &&
            (prev_key_r == stg_key_r[LAST]);
  end

  // Track the last pushed transaction and raise the sticky hazard flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vld_r   <= 1'b0;
      prev_type_r  <= TYPE_RESET;
      prev_key_r   <= {KEY_W{1'b0}};
      prev_wdata_r <= {VAL_W{1'b0}};
      prev_ltime_r <= {LTIME_W{1'b0}};
      cov_ww_r     <= 1'b0;
      cov_wr_r     <= 1'b0;
    end else if (push_ok_s) begin
      prev_vld_r   <= 1'b1;
      prev_type_r  <= stg_type_r[LAST];
      prev_key_r   <= stg_key_r[LAST];
      prev_wdata_r <= stg_wdata_r[LAST];
      prev_ltime_r <= stg_ltime_r[LAST];
      if (adj_s && (stg_type_r[LAST] == TYPE_WRITE) &&
          (stg_wdata_r[LAST] != prev_wdata_r)) begin
        cov_ww_r <= 1'b1;
      end else begin
        cov_ww_r <= cov_ww_r;
      end
      if (adj_s && (stg_type_r[LAST] == TYPE_READ)) begin
        cov_wr_r <= 1'b1;
      end else begin
        cov_wr_r <= cov_wr_r;
      end
    end else begin
      prev_vld_r <= prev_vld_r;
      cov_ww_r   <= cov_ww_r;
      cov_wr_r   <= cov_wr_r;
    end
  end

  assign cov_ww = cov_ww_r;
  assign cov_wr = cov_wr_r;
`endif

endmodule

// File: tb/tb_cam_tr_monitor.sv
// Bench for cam_tr_monitor: two instances (READ_LAT = 1 and 3) share the same
// stimulus. A transaction-level reference model (in-flight list plus FIFO
// list) predicts the head, drop count and overflow of each instance every cycle.
module tb_cam_tr_monitor;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [1:0]  typ;
    logic [15:0] key;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        vo;
    logic [31:0] lt;
  } ent_t;

  logic        clk_s = 1'b0;
  logic        rst_s;
  logic        cv_s;
  logic        rw_s;
  logic [15:0] key_s;
  logic [15:0] val_s;
  logic [15:0] cam_val_s;
  logic        cam_hit_s;
  logic        rdy_s;

  logic        tv_s   [2];
  logic [1:0]  tt_s   [2];
  logic [15:0] tk_s   [2];
  logic [15:0] tw_s   [2];
  logic [15:0] tr_s   [2];
  logic        tvo_s  [2];
  logic [31:0] tl_s   [2];
  logic [15:0] drop_s [2];
  logic        ovf_s  [2];
`ifdef CAM_TRMON_COV_EN
  logic        cww_s  [2];
  logic        cwr_s  [2];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_s = ~clk_s;

  cam_tr_monitor #(.READ_LAT(1), .DEPTH(DEPTH)) dut1 (
    .clk(clk_s), .rst(rst_s), .cam_valid_i(cv_s), .cam_rw_n_i(rw_s),
    .cam_key_i(key_s), .cam_val_i(val_s), .cam_val_o(cam_val_s),
    .cam_valid_o(cam_hit_s), .tr_valid(tv_s[0]), .tr_ready(rdy_s),
    .tr_type(tt_s[0]), .tr_key(tk_s[0]), .tr_wdata(tw_s[0]),
    .tr_rdata(tr_s[0]), .tr_valid_o(tvo_s[0]), .tr_ltime(tl_s[0]),
    .drop_cnt(drop_s[0]),
`ifdef CAM_TRMON_COV_EN
    .cov_ww(cww_s[0]), .cov_wr(cwr_s[0]),
`endif
    .overflow(ovf_s[0]));

  cam_tr_monitor #(.READ_LAT(3), .DEPTH(DEPTH)) dut3 (
    .clk(clk_s), .rst(rst_s), .cam_valid_i(cv_s), .cam_rw_n_i(rw_s),
    .cam_key_i(key_s), .cam_val_i(val_s), .cam_val_o(cam_val_s),
    .cam_valid_o(cam_hit_s), .tr_valid(tv_s[1]), .tr_ready(rdy_s),
    .tr_type(tt_s[1]), .tr_key(tk_s[1]), .tr_wdata(tw_s[1]),
    .tr_rdata(tr_s[1]), .tr_valid_o(tvo_s[1]), .tr_ltime(tl_s[1]),
    .drop_cnt(drop_s[1]),
`ifdef CAM_TRMON_COV_EN
    .cov_ww(cww_s[1]), .cov_wr(cwr_s[1]),
`endif
    .overflow(ovf_s[1]));

  // ------------------------------------------------------ reference model
  ent_t        m_fifo  [2][0:DEPTH-1];
  int          m_n     [2];
  ent_t        m_inf   [2][0:7];
  int          m_due   [2][0:7];
  int          m_inf_n [2];
  logic [15:0] m_drop  [2];
  logic        m_ovf   [2];
  logic [31:0] m_lt;
  int          cyc = 0;
  int          lat_of [2] = '{1, 3};

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge of the transaction-level model for instance d.
  task automatic model_edge(input int d);
    ent_t e;
    bit   pop;
    if (rst_s) begin
      m_n[d]     = 0;
      m_drop[d]  = 16'd0;
      m_ovf[d]   = 1'b0;
      e          = '0;
      m_inf[d][0] = e;
      m_due[d][0] = cyc + lat_of[d];
      m_inf_n[d] = 1;
    end else begin
      pop = (m_n[d] > 0) && rdy_s;
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) m_fifo[d][i] = m_fifo[d][i+1];
        m_n[d]--;
      end
      if (m_inf_n[d] > 0 && m_due[d][0] == cyc) begin
        e = m_inf[d][0];
        for (int i = 0; i < 7; i++) begin
          m_inf[d][i] = m_inf[d][i+1];
          m_due[d][i] = m_due[d][i+1];
        end
        m_inf_n[d]--;
        if (e.typ == 2'd1) begin
          e.rdata = cam_val_s;
          e.vo    = cam_hit_s;
        end
        if (m_n[d] < DEPTH) begin
          m_fifo[d][m_n[d]] = e;
          m_n[d]++;
        end else begin
          m_ovf[d] = 1'b1;
          if (m_drop[d] != 16'hFFFF) m_drop[d] = m_drop[d] + 16'd1;
        end
      end
      if (cv_s) begin
        e       = '0;
        e.typ   = rw_s ? 2'd1 : 2'd2;
        e.key   = key_s;
        e.wdata = rw_s ? 16'd0 : val_s;
        e.lt    = m_lt;
        m_inf[d][m_inf_n[d]] = e;
        m_due[d][m_inf_n[d]] = cyc + lat_of[d];
        m_inf_n[d]++;
      end
    end
  endtask

  // Advance one clock, update the model, then compare both instances.
  task automatic step();
    logic [127:0] exp;
    logic [127:0] got;
    @(posedge clk_s);
    model_edge(0);
    model_edge(1);
    m_lt = rst_s ? 32'd1 : m_lt + 32'd1;
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) begin
      got = {tv_s[d], tt_s[d], tk_s[d], tw_s[d], tr_s[d], tvo_s[d], tl_s[d],
             drop_s[d], ovf_s[d]};
      if (m_n[d] > 0) exp = {1'b1, m_fifo[d][0], m_drop[d], m_ovf[d]};
      else            exp = {1'b0, 83'd0, m_drop[d], m_ovf[d]};
      check_val(d == 0 ? "lat1_state" : "lat3_state", got, exp);
    end
  endtask

  task automatic idle();
    cv_s      = 1'b0;
    rw_s      = 1'b0;
    key_s     = 16'd0;
    val_s     = 16'd0;
  endtask

  task automatic do_write(input logic [15:0] k, input logic [15:0] v);
    cv_s = 1'b1; rw_s = 1'b0; key_s = k; val_s = v;
  endtask

  task automatic do_read(input logic [15:0] k);
    cv_s = 1'b1; rw_s = 1'b1; key_s = k; val_s = 16'($urandom);
  endtask

  initial begin
    rst_s = 1'b1; rdy_s = 1'b1; cam_val_s = 16'd0; cam_hit_s = 1'b0;
    idle();
    m_lt = 32'd1;

    // Reset held for 3 cycles with junk requests that must be ignored.
    for (int i = 0; i < 3; i++) begin
      do_write(16'($urandom), 16'($urandom));
      step();
    end
    rst_s = 1'b0;
    idle();
    cam_val_s = 16'hBEEF; cam_hit_s = 1'b1;
    step();  // ltime 1
    check_val("rst_token", {tv_s[0], tt_s[0], tl_s[0], drop_s[0]},
              {1'b1, 2'd0, 32'd0, 16'd0});
    step();  // ltime 2
    step();  // ltime 3
    step();  // ltime 4
    do_write(16'h0012, 16'hBEEF);
    step();  // write sampled at ltime 5
    do_read(16'h0012);
    step();  // read sampled at ltime 6
    idle();
    check_val("wr_head", {tv_s[0], tt_s[0], tk_s[0], tw_s[0], tl_s[0]},
              {1'b1, 2'd2, 16'h0012, 16'hBEEF, 32'd5});
    step();
    check_val("rd_head", {tv_s[0], tt_s[0], tk_s[0], tr_s[0], tvo_s[0], tl_s[0]},
              {1'b1, 2'd1, 16'h0012, 16'hBEEF, 1'b1, 32'd6});
    for (int i = 0; i < 6; i++) step();

    // Latency-3 read: response only valid in the third cycle.
    do_read(16'h0007);
    step();
    idle();
    cam_val_s = 16'hDEAD; cam_hit_s = 1'b0;
    step();
    step();
    cam_val_s = 16'h1234; cam_hit_s = 1'b1;
    step();
    check_val("lat3_read", {tv_s[1], tt_s[1], tk_s[1], tr_s[1], tvo_s[1]},
              {1'b1, 2'd1, 16'h0007, 16'h1234, 1'b1});
    for (int i = 0; i < 4; i++) step();

    // Overflow: ready low, reset, ten back-to-back writes.
    rdy_s = 1'b0;
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_write(16'(16'h0100 + i), 16'($urandom));
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();
    check_val("ovf_drop1", {drop_s[0], ovf_s[0]}, {16'd3, 1'b1});
    check_val("ovf_drop3", {drop_s[1], ovf_s[1]}, {16'd3, 1'b1});

    // Full FIFO: write reaches latency-1 FIFO in the one cycle ready is high.
    do_write(16'h0AAA, 16'h5555);
    step();
    idle();
    rdy_s = 1'b1;
    step();
    rdy_s = 1'b0;
    check_val("full_pop_drop1", {drop_s[0], tv_s[0]}, {16'd3, 1'b1});
    for (int i = 0; i < 3; i++) step();
    rdy_s = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // Reset mid-stream with entries queued and a read in flight.
    rdy_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_write(16'(i), 16'($urandom));
      step();
    end
    do_read(16'h0003);
    step();
    idle();
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    rdy_s = 1'b1;
    step();
    check_val("mid_rst_token", {tv_s[0], tt_s[0], tl_s[0], drop_s[0]},
              {1'b1, 2'd0, 32'd0, 16'd0});
    for (int i = 0; i < 6; i++) step();

    // Random traffic with random backpressure and rare resets.
    for (int i = 0; i < 600; i++) begin
      cv_s      = ($urandom_range(0, 99) < 60);
      rw_s      = 1'($urandom);
      key_s     = 16'($urandom_range(0, 3));
      val_s     = 16'($urandom);
      cam_val_s = 16'($urandom);
      cam_hit_s = 1'($urandom);
      rdy_s     = ($urandom_range(0, 99) < 55);
      rst_s     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_s = 1'b0;
    idle();
    rdy_s = 1'b1;
    for (int i = 0; i < 12; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
